// File: rtl/lap_display_mgr.sv
// rtl/lap_display_mgr.sv - stopwatch display manager: live, frozen-split and lap-recall views
module lap_display_mgr #(
  parameter int NDIG = 8,
  parameter int LAPS = 4,
  parameter int LW   = $clog2(LAPS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blink_tick,
  input  logic              split_btn,
  input  logic              recall_btn,
  input  logic              clear_btn,
  input  logic [4*NDIG-1:0] time_in,
  output logic [6*NDIG-1:0] disp_out,
  output logic [1:0]        mode,
  output logic [LW-1:0]     lap_count,
  output logic              full
);

  typedef enum logic [1:0] {
    LIVE   = 2'd0,
    FROZEN = 2'd1,
    RECALL = 2'd2
  } mode_e;

  localparam int         TW      = 4 * NDIG;
  localparam logic [5:0] DIG_RST = 6'b100000;

  mode_e             mode_q, mode_d;
  logic [LW-1:0]     lap_count_q, lap_count_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic              full_q, full_d;
  logic              blank_q, blank_d;
  logic [TW-1:0]     frz_q, frz_d;
  logic [TW-1:0]     lap_mem_q [LAPS];
  logic [TW-1:0]     lap_mem_d [LAPS];
  logic [6*NDIG-1:0] disp_q, disp_d;
  logic [TW-1:0]     rec_word;
  logic              do_clear, do_split, do_recall, lap_wr;

  always_comb begin
    do_clear    = clear_btn;
    do_split    = split_btn & ~clear_btn;
    do_recall   = recall_btn & ~clear_btn & ~split_btn;
    mode_d      = mode_q;
    lap_count_d = lap_count_q;
    idx_d       = idx_q;
    frz_d       = frz_q;
    lap_wr      = 1'b0;
    blank_d     = blank_q ^ (blink_tick && (mode_q == FROZEN));

    if (do_clear) begin
      lap_count_d = '0;
      mode_d      = LIVE;
    end else if (do_split) begin
      if (mode_q == LIVE) begin
        frz_d   = time_in;
        mode_d  = FROZEN;
        blank_d = 1'b0;
        // A split while full still freezes; only the lap store is skipped
        if (!full_q) begin
          lap_wr      = 1'b1;
          lap_count_d = lap_count_q + LW'(1);
        end
      end else begin
        mode_d = LIVE;
      end
    end else if (do_recall) begin
      if (mode_q == RECALL) begin
        if (idx_q == lap_count_q - LW'(1)) begin
          mode_d = LIVE;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end else if (lap_count_q != '0) begin
        mode_d = RECALL;
        idx_d  = '0;
      end
    end

    if (mode_d != FROZEN) begin
      blank_d = 1'b0;
    end
    full_d = (lap_count_d == LW'(LAPS));
  end

  always_comb begin
    for (int i = 0; i < LAPS; i++) begin
      lap_mem_d[i] = lap_mem_q[i];
      if (lap_wr && (lap_count_q == LW'(i))) begin
        lap_mem_d[i] = time_in;
      end
    end
  end

  always_comb begin
    rec_word = '0;
    for (int i = 0; i < LAPS; i++) begin
      if (idx_d == LW'(i)) begin
        rec_word = lap_mem_q[i];
      end
    end
  end

  // Display is built from the next state so it lines up with mode/lap_count
  always_comb begin
    disp_d = '0;
    for (int k = 0; k < NDIG; k++) begin
      case (mode_d)
        LIVE:    disp_d[6*k +: 6] = {1'b1, time_in[4*k +: 4], 1'b0};
        FROZEN:  disp_d[6*k +: 6] = {~blank_d, frz_d[4*k +: 4], 1'b0};
        RECALL:  disp_d[6*k +: 6] = {1'b1, rec_word[4*k +: 4],
                                     (k < LAPS) && (idx_d == LW'(k))};
        default: disp_d[6*k +: 6] = DIG_RST;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= LIVE;
      lap_count_q <= '0;
      idx_q       <= '0;
      full_q      <= 1'b0;
      blank_q     <= 1'b0;
      frz_q       <= '0;
      disp_q      <= {NDIG{DIG_RST}};
      for (int i = 0; i < LAPS; i++) begin
        lap_mem_q[i] <= '0;
      end
    end else begin
      mode_q      <= mode_d;
      lap_count_q <= lap_count_d;
      idx_q       <= idx_d;
      full_q      <= full_d;
      blank_q     <= blank_d;
      frz_q       <= frz_d;
      disp_q      <= disp_d;
      for (int i = 0; i < LAPS; i++) begin
        lap_mem_q[i] <= lap_mem_d[i];
      end
    end
  end

  assign disp_out  = disp_q;
  assign mode      = mode_q;
  assign lap_count = lap_count_q;
  assign full      = full_q;

endmodule

// File: tb/tb_lap_display_mgr.sv
// tb/tb_lap_display_mgr.sv - scoreboard bench for lap_display_mgr with a queue-based lap model
module tb_lap_display_mgr;

  localparam int NDIG = 8;
  localparam int LAPS = 4;
  localparam int LW   = $clog2(LAPS + 1);
  localparam int TW   = 4 * NDIG;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              blink_tick = 1'b0;
  logic              split_btn = 1'b0;
  logic              recall_btn = 1'b0;
  logic              clear_btn = 1'b0;
  logic [TW-1:0]     time_in = '0;
  logic [6*NDIG-1:0] disp_out;
  logic [1:0]        mode;
  logic [LW-1:0]     lap_count;
  logic              full;

  always #5 clk = ~clk;

  lap_display_mgr #(.NDIG(NDIG), .LAPS(LAPS)) dut (
    .clk        (clk),
    .rst        (rst),
    .blink_tick (blink_tick),
    .split_btn  (split_btn),
    .recall_btn (recall_btn),
    .clear_btn  (clear_btn),
    .time_in    (time_in),
    .disp_out   (disp_out),
    .mode       (mode),
    .lap_count  (lap_count),
    .full       (full)
  );

  typedef struct {
    logic [6*NDIG-1:0] disp;
    logic [1:0]        mode;
    logic [LW-1:0]     lc;
    logic              full;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: 0 live, 1 frozen, 2 recall; laps kept as a plain queue
  int            m_mode;
  logic [TW-1:0] m_laps[$];
  logic [TW-1:0] m_frz;
  bit            m_blank;
  int            m_idx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_laps.delete();
    m_frz   = '0;
    m_blank = 0;
    m_idx   = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic s, input logic r, input logic c, input logic t,
                            input logic [TW-1:0] tin);
    bit was_frozen;
    was_frozen = (m_mode == 1);
    if (c) begin
      m_laps.delete();
      m_mode = 0;
    end else if (s) begin
      if (m_mode == 0) begin
        m_frz = tin;
        if (m_laps.size() < LAPS) m_laps.push_back(tin);
        m_mode  = 1;
        m_blank = 0;
        was_frozen = 0;
      end else begin
        m_mode = 0;
      end
    end else if (r) begin
      if (m_mode == 2) begin
        if (m_idx == m_laps.size() - 1) m_mode = 0;
        else m_idx++;
      end else if (m_laps.size() > 0) begin
        m_mode = 2;
        m_idx  = 0;
      end
    end
    if (t && was_frozen && m_mode == 1) m_blank = ~m_blank;
    if (m_mode != 1) m_blank = 0;
  endtask

  function automatic logic [6*NDIG-1:0] model_disp(input logic [TW-1:0] tin);
    logic [6*NDIG-1:0] d;
    logic [TW-1:0]     w;
    d = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (m_mode == 0) begin
        d[6*k +: 6] = {1'b1, tin[4*k +: 4], 1'b0};
      end else if (m_mode == 1) begin
        d[6*k +: 6] = {~m_blank, m_frz[4*k +: 4], 1'b0};
      end else begin
        w = m_laps[m_idx];
        d[6*k +: 6] = {1'b1, w[4*k +: 4], (k == m_idx)};
      end
    end
    return d;
  endfunction

  task automatic cyc(input logic s, input logic r, input logic c, input logic t,
                     input logic [TW-1:0] tin);
    exp_t e;
    @(negedge clk);
    split_btn  = s;
    recall_btn = r;
    clear_btn  = c;
    blink_tick = t;
    time_in    = tin;
    model_step(s, r, c, t, tin);
    e.disp = model_disp(tin);
    e.mode = 2'(m_mode);
    e.lc   = LW'(m_laps.size());
    e.full = (m_laps.size() == LAPS);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_disp"}, 64'(disp_out), 64'({NDIG{6'b100000}}));
    check({tag, "_mode"}, 64'(mode), 64'(0));
    check({tag, "_lap_count"}, 64'(lap_count), 64'(0));
    check({tag, "_full"}, 64'(full), 64'(0));
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst        = 1'b1;
    split_btn  = 1'b0;
    recall_btn = 1'b0;
    clear_btn  = 1'b0;
    blink_tick = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [TW-1:0] rand_bcd();
    logic [TW-1:0] v;
    for (int k = 0; k < NDIG; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
    return v;
  endfunction

  // Monitor: outputs are valid every cycle, so one expectation is consumed per edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("disp_out", 64'(disp_out), 64'(e.disp));
        check("mode", 64'(mode), 64'(e.mode));
        check("lap_count", 64'(lap_count), 64'(e.lc));
        check("full", 64'(full), 64'(e.full));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] vals [5];
    logic [TW-1:0] tin;
    logic          s, r, c, t;
    vals = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h55555555};
    model_reset();
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    repeat (3) cyc(0, 0, 0, 0, 32'h12345678);

    cyc(1, 0, 0, 0, 32'h00001234);
    cyc(0, 0, 0, 0, 32'h00009999);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, 32'h00009999);
      cyc(0, 0, 0, 0, 32'h00008888);
    end
    cyc(1, 0, 0, 0, 32'h00007777);
    cyc(0, 0, 1, 0, 32'h00007777);

    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, vals[i]);
      cyc(0, 0, 0, 0, 32'h00000000);
      cyc(1, 0, 0, 0, 32'h00000001);
    end
    repeat (5) cyc(0, 1, 0, 0, 32'h00000002);
    cyc(0, 0, 1, 0, 32'h00000003);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, vals[4 - i]);
      cyc(1, 0, 0, 0, 32'h00000004);
    end
    repeat (4) cyc(0, 1, 0, 0, 32'h00000005);

    cyc(0, 1, 0, 0, 32'h00000006);
    cyc(1, 1, 1, 0, 32'h00000007);
    cyc(0, 1, 0, 0, 32'h00000008);
    cyc(0, 0, 0, 0, 32'h00000009);

    cyc(1, 0, 0, 0, 32'h87654321);
    cyc(0, 0, 0, 1, 32'h00000000);
    async_reset();

    tin = rand_bcd();
    for (int n = 0; n < 3000; n++) begin
      s = ($urandom_range(0, 11) == 0);
      r = ($urandom_range(0, 7) == 0);
      c = ($urandom_range(0, 39) == 0);
      t = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) tin = rand_bcd();
      cyc(s, r, c, t, tin);
      if ($urandom_range(0, 499) == 0) async_reset();
    end
    cyc(0, 0, 0, 0, tin);
    cyc(0, 0, 0, 0, tin);

    repeat (2) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
